sdf_bf_stage4: RTL and testbench

Radix-2 single-path delay-feedback (SDF) butterfly stage with a 4-entry complex delay line, sitting directly downstream of the 16-point FFT's stage-4 twiddle ROM. It consumes that ROM's `state` phase and `w_r`/`w_i` twiddle words. It emits the sum `x[n]+x[n+4]` during the butterfly phase and the twiddled difference `(x[n]-x[n+4])·W` during the twiddle phase. Output is one complex sample per cycle to the next (delay-2) stage.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_cmul.sv | 32 +++
 rtl/sdf_bf_stage4.sv | 102 ++++++++++
 tb/tb_sdf_bf_stage4.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the 16-point SDF FFT datapath.
package fft_pkg;

    localparam int DATA_W = 24;
    localparam int FRAC_W = 8;
    localparam int DEPTH  = 4;

    // Phase reported by each stage's twiddle ROM.
    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BFLY = 2'd1,
        ST_TWID = 2'd2,
        ST_ILL  = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_cmul.sv
// Combinational fixed-point complex multiply: full-width products, arithmetic
// shift right by FRAC_W (floor), then wrap to DATA_W bits.
module fft_cmul
    import fft_pkg::*;
(
    input  cplx_t i_a,
    input  cplx_t i_w,
    output cplx_t o_p
);

    localparam int PW = 2 * DATA_W + 1;

    logic signed [PW-1:0] w_ar, w_ai, w_wr, w_wi;
    logic signed [PW-1:0] w_re_full, w_im_full;
    logic                 w_unused_bits;

    assign w_ar = PW'(i_a.re);
    assign w_ai = PW'(i_a.im);
    assign w_wr = PW'(i_w.re);
    assign w_wi = PW'(i_w.im);

    assign w_re_full = (w_ar * w_wr) - (w_ai * w_wi);
    assign w_im_full = (w_ar * w_wi) + (w_ai * w_wr);

    // Taking bits above FRAC_W of the two's-complement sum is the floor shift plus wrap.
    assign o_p.re = w_re_full[FRAC_W +: DATA_W];
    assign o_p.im = w_im_full[FRAC_W +: DATA_W];

    assign w_unused_bits = ^{w_re_full[PW-1:FRAC_W+DATA_W], w_re_full[FRAC_W-1:0],
                             w_im_full[PW-1:FRAC_W+DATA_W], w_im_full[FRAC_W-1:0]};

endmodule

// File: rtl/sdf_bf_stage4.sv
// Radix-2 SDF butterfly stage with a 4-deep complex feedback delay line.
// Emits x[n]+x[n+4] in the butterfly phase and (x[n]-x[n+4])*W in the twiddle phase.
module sdf_bf_stage4
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] din_r,
    input  logic [DATA_W-1:0] din_i,
    input  logic [1:0]        state,
    input  logic [DATA_W-1:0] w_r,
    input  logic [DATA_W-1:0] w_i,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout_r,
    output logic [DATA_W-1:0] dout_i
);

    cplx_t            r_dl [DEPTH];
    logic [DEPTH-1:0] r_dl_v;
    cplx_t            r_dout;
    logic             r_out_valid;

    cplx_t  w_head, w_din, w_tw, w_prod, w_push, w_nxt_dout;
    logic   w_head_v, w_shift, w_push_v, w_nxt_ov;
    state_e w_state;

    assign w_head   = r_dl[0];
    assign w_head_v = r_dl_v[0];
    assign w_din    = {din_r, din_i};
    assign w_tw     = {w_r, w_i};
    assign w_state  = state_e'(state);

    fft_cmul u_cmul (
        .i_a (w_head),
        .i_w (w_tw),
        .o_p (w_prod)
    );

    always_comb begin
        w_shift    = 1'b0;
        w_push     = w_din;
        w_push_v   = 1'b0;
        w_nxt_dout = r_dout;
        w_nxt_ov   = 1'b0;
        case (w_state)
            ST_FILL: begin
                w_shift  = in_valid;
                w_push_v = 1'b1;
            end
            ST_BFLY: begin
                w_shift       = 1'b1;
                w_nxt_dout.re = w_head.re + w_din.re;
                w_nxt_dout.im = w_head.im + w_din.im;
                w_push.re     = w_head.re - w_din.re;
                w_push.im     = w_head.im - w_din.im;
                w_push_v      = w_head_v & in_valid;
                w_nxt_ov      = w_head_v & in_valid;
            end
            ST_TWID: begin
                w_shift    = 1'b1;
                w_nxt_dout = w_prod;
                w_nxt_ov   = w_head_v;
                w_push_v   = in_valid;
            end
            default: begin
                // Bubble: line frozen, data outputs hold.
            end
        endcase
    end

    // Index 0 is the oldest entry; pushes enter at DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_dl[i] <= '0;
            end
            r_dl_v <= '0;
        end else if (w_shift) begin
            for (int i = 0; i < DEPTH-1; i++) begin
                r_dl[i] <= r_dl[i+1];
            end
            r_dl[DEPTH-1] <= w_push;
            r_dl_v        <= {w_push_v, r_dl_v[DEPTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_dout      <= w_nxt_dout;
            r_out_valid <= w_nxt_ov;
        end
    end

    assign out_valid = r_out_valid;
    assign dout_r    = r_dout.re;
    assign dout_i    = r_dout.im;

endmodule

// File: tb/tb_sdf_bf_stage4.sv
// Bench for sdf_bf_stage4: queue-based reference model, per-cycle compare, directed literal checks.
module tb_sdf_bf_stage4;

    localparam int W = 24;

    typedef struct {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         v;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [1:0]   state = 2'd0;
    logic [W-1:0] din_r = '0, din_i = '0, w_r = '0, w_i = '0;
    logic         out_valid;
    logic [W-1:0] dout_r, dout_i;

    int n_vec = 0;
    int n_err = 0;

    ent_t         line[$];
    logic         exp_ov;
    logic [W-1:0] exp_r, exp_i;
    logic [W-1:0] rom_r [4];
    logic [W-1:0] rom_i [4];

    sdf_bf_stage4 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .state     (state),
        .w_r       (w_r),
        .w_i       (w_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    always #5 clk = ~clk;

    function automatic longint sx(input logic [W-1:0] v);
        longint t;
        t = longint'(v);
        if (v[W-1]) t = t - (longint'(1) << W);
        return t;
    endfunction

    // Complex product with floor division by 2^8, wrapped to W bits.
    function automatic logic [W-1:0] fix_mul(input logic [W-1:0] ar, ai, br, bi, input bit imag);
        longint     p;
        logic [63:0] u;
        if (!imag) p = sx(ar) * sx(br) - sx(ai) * sx(bi);
        else       p = sx(ar) * sx(bi) + sx(ai) * sx(br);
        p = p >>> 8;
        u = p;
        return u[W-1:0];
    endfunction

    task automatic model_reset();
        ent_t z;
        z.re = '0; z.im = '0; z.v = 1'b0;
        line.delete();
        for (int i = 0; i < 4; i++) line.push_back(z);
        exp_ov = 1'b0;
        exp_r  = '0;
        exp_i  = '0;
    endtask

    // Drive one cycle and advance the model; returns 1 time unit after the sampling edge.
    task automatic step(input logic [1:0] st, input bit iv, input logic [W-1:0] dr, di, wr, wi);
        ent_t h, e;
        @(negedge clk);
        state = st; in_valid = iv; din_r = dr; din_i = di; w_r = wr; w_i = wi;
        exp_ov = 1'b0;
        case (st)
            2'd0: if (iv) begin
                h = line.pop_front();
                e.re = dr; e.im = di; e.v = 1'b1;
                line.push_back(e);
            end
            2'd1: begin
                h = line.pop_front();
                exp_r  = h.re + dr;
                exp_i  = h.im + di;
                exp_ov = h.v & iv;
                e.re = h.re - dr; e.im = h.im - di; e.v = h.v & iv;
                line.push_back(e);
            end
            2'd2: begin
                h = line.pop_front();
                exp_r  = fix_mul(h.re, h.im, wr, wi, 1'b0);
                exp_i  = fix_mul(h.re, h.im, wr, wi, 1'b1);
                exp_ov = h.v;
                e.re = dr; e.im = di; e.v = iv;
                line.push_back(e);
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
    endtask

    // Per-cycle compare against the model.
    always @(posedge clk) begin
        #1;
        n_vec++;
        if (out_valid !== exp_ov || (exp_ov && (dout_r !== exp_r || dout_i !== exp_i))) begin
            n_err++;
            $display("FAIL model_cmp t=%0t: got valid=%0b dout=(%0h,%0h), want valid=%0b dout=(%0h,%0h)",
                     $time, out_valid, dout_r, dout_i, exp_ov, exp_r, exp_i);
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0; state = 2'd0;
        model_reset();
        #1;
        chk("reset_valid", W'(out_valid), '0);
        chk("reset_dout_r", dout_r, '0);
        chk("reset_dout_i", dout_i, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic const_test();
        for (int k = 0; k < 4; k++) begin
            step(2'd0, 1'b1, W'(256), '0, rom_r[k], rom_i[k]);
            chk("const_fill_valid", W'(out_valid), '0);
        end
        for (int k = 0; k < 4; k++) begin
            step(2'd1, 1'b1, W'(256), '0, rom_r[k], rom_i[k]);
            chk("const_bfly_valid", W'(out_valid), W'(1));
            chk("const_bfly_r", dout_r, W'(512));
            chk("const_bfly_i", dout_i, '0);
        end
        for (int k = 0; k < 4; k++) begin
            step(2'd2, 1'b0, '0, '0, rom_r[k], rom_i[k]);
            chk("const_twid_valid", W'(out_valid), W'(1));
            chk("const_twid_r", dout_r, '0);
            chk("const_twid_i", dout_i, '0);
        end
    endtask

    function automatic logic [W-1:0] rnd_d();
        if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 1023)) - W'(512);
        return W'($urandom);
    endfunction

    initial begin
        int vcnt;
        logic [W-1:0] fillv [4];
        logic [W-1:0] fr, fi, twr, twi;
        rom_r[0] = W'(256); rom_i[0] = '0;
        rom_r[1] = W'(181); rom_i[1] = 24'hFFFF4B;
        rom_r[2] = '0;      rom_i[2] = 24'hFFFF00;
        rom_r[3] = 24'hFFFF4B; rom_i[3] = 24'hFFFF4B;
        model_reset();
        do_reset();

        // Constant input, then drain: exactly 4 valid twiddle outputs, then nothing.
        const_test();
        vcnt = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(2'd1, 1'b0, '0, '0, rom_r[k], rom_i[k]);
                vcnt += int'(out_valid);
            end
            for (int k = 0; k < 4; k++) begin
                step(2'd2, 1'b0, '0, '0, rom_r[k], rom_i[k]);
                vcnt += int'(out_valid);
            end
        end
        chk("flush_no_extra_valid", W'(vcnt), '0);

        // Impulse.
        do_reset();
        for (int k = 0; k < 4; k++) step(2'd0, 1'b1, (k == 0) ? W'(256) : '0, '0, rom_r[k], rom_i[k]);
        for (int k = 0; k < 4; k++) begin
            step(2'd1, 1'b1, '0, '0, rom_r[k], rom_i[k]);
            chk("imp_bfly_r", dout_r, (k == 0) ? W'(256) : '0);
            chk("imp_bfly_valid", W'(out_valid), W'(1));
        end
        for (int k = 0; k < 4; k++) begin
            step(2'd2, 1'b0, '0, '0, rom_r[k], rom_i[k]);
            chk("imp_twid_r", dout_r, (k == 0) ? W'(256) : '0);
            chk("imp_twid_i", dout_i, '0);
        end

        // Twiddle math on differences 0,256,256,0.
        do_reset();
        fillv[0] = '0; fillv[1] = W'(256); fillv[2] = W'(256); fillv[3] = '0;
        for (int k = 0; k < 4; k++) step(2'd0, 1'b1, fillv[k], '0, rom_r[k], rom_i[k]);
        for (int k = 0; k < 4; k++) step(2'd1, 1'b1, '0, '0, rom_r[k], rom_i[k]);
        for (int k = 0; k < 4; k++) begin
            step(2'd2, 1'b0, '0, '0, rom_r[k], rom_i[k]);
            if (k == 1) begin
                chk("twid_181_r", dout_r, W'(181));
                chk("twid_181_i", dout_i, 24'hFFFF4B);
            end
            if (k == 2) begin
                chk("twid_mj_r", dout_r, '0);
                chk("twid_mj_i", dout_i, 24'hFFFF00);
            end
        end

        // Wrap: max positive on both halves.
        do_reset();
        for (int k = 0; k < 4; k++) step(2'd0, 1'b1, 24'h7FFFFF, 24'h7FFFFF, rom_r[k], rom_i[k]);
        step(2'd1, 1'b1, 24'h7FFFFF, 24'h7FFFFF, rom_r[0], rom_i[0]);
        chk("wrap_sum_r", dout_r, 24'hFFFFFE);
        chk("wrap_sum_i", dout_i, 24'hFFFFFE);
        chk("wrap_valid", W'(out_valid), W'(1));
        for (int k = 1; k < 4; k++) step(2'd1, 1'b1, 24'h7FFFFF, 24'h7FFFFF, rom_r[k], rom_i[k]);
        step(2'd2, 1'b0, '0, '0, rom_r[0], rom_i[0]);
        chk("wrap_diff_r", dout_r, '0);

        // Single-cycle gap in butterfly phase.
        do_reset();
        for (int k = 0; k < 4; k++) step(2'd0, 1'b1, W'(256), '0, rom_r[k], rom_i[k]);
        for (int k = 0; k < 4; k++) begin
            step(2'd1, (k != 1), W'(256), '0, rom_r[k], rom_i[k]);
            chk("gap_bfly_valid", W'(out_valid), (k == 1) ? '0 : W'(1));
        end
        for (int k = 0; k < 4; k++) begin
            step(2'd2, 1'b0, '0, '0, rom_r[k], rom_i[k]);
            chk("gap_twid_valid", W'(out_valid), (k == 1) ? '0 : W'(1));
        end

        // Reset mid-butterfly, then the constant result must repeat.
        do_reset();
        for (int k = 0; k < 4; k++) step(2'd0, 1'b1, W'(256), '0, rom_r[k], rom_i[k]);
        for (int k = 0; k < 2; k++) step(2'd1, 1'b1, W'(256), '0, rom_r[k], rom_i[k]);
        do_reset();
        const_test();

        // Randomized frames with gaps, bubbles and arbitrary twiddles.
        for (int rr = 0; rr < 3; rr++) begin
            do_reset();
            for (int k = 0; k < 4; k++) step(2'd0, ($urandom_range(0, 9) != 0), rnd_d(), rnd_d(), '0, '0);
            for (int b = 0; b < 40; b++) begin
                for (int k = 0; k < 4; k++) begin
                    if ($urandom_range(0, 9) == 0) step(2'd3, 1'b1, rnd_d(), rnd_d(), rnd_d(), rnd_d());
                    fr = rnd_d(); fi = rnd_d();
                    if ($urandom_range(0, 1) == 0) begin twr = rom_r[k]; twi = rom_i[k]; end
                    else begin twr = rnd_d(); twi = rnd_d(); end
                    step((b % 2 == 0) ? 2'd1 : 2'd2, ($urandom_range(0, 7) != 0), fr, fi, twr, twi);
                end
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
